// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//   Bit-serial ripple adder. One full-adder cell is reused over WIDTH clock
//   cycles, LSB first, with a registered carry. Produces the sum, the
//   unsigned carry-out and the two's-complement overflow flag.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   launch an addition when idle (ignored while busy)
//   a, b   in   WIDTH-bit operands, sampled only on an accepted start
//   cin    in   carry-in, sampled only on an accepted start
//   busy   out  high while an addition is in progress
//   done   out  one-cycle pulse: sum/cout/ovf were just updated
//   sum    out  a+b+cin mod 2^WIDTH (held until the next completion)
//   cout   out  unsigned carry-out
//   ovf    out  signed overflow (carry into MSB XOR carry out of MSB)
// ---------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic             fa_s;
  logic             fa_c;

  // Single full-adder cell working on the current LSBs.
  assign fa_s = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
  assign fa_c = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        // The augend register doubles as the result register: each consumed
        // augend bit frees the MSB slot that the new sum bit shifts into, so
        // after WIDTH shifts it holds the complete sum with bit 0 as LSB.
        a_sh_d  = (a_sh_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
        b_sh_d  = b_sh_q >> 1;
        carry_d = fa_c;
        if (cnt_q == LAST_CNT) begin
          // carry_q is the carry into the MSB at this point.
          sum_d   = (a_sh_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
          cout_d  = fa_c;
          ovf_d   = carry_q ^ fa_c;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//   Scoreboard bench for serial_adder at WIDTH = 4, 1 and 8. Stimulus pushes
//   the expected result and the expected done cycle into a per-instance
//   queue; independent monitors pop and compare on every done pulse.
// ---------------------------------------------------------------------------
module tb_serial_adder;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    longint      cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  longint cyc;

  int n_tests;
  int n_fail;

  exp_t q4[$];
  exp_t q1[$];
  exp_t q8[$];

  // WIDTH = 4 instance
  logic       start4, cin4, busy4, done4, cout4, ovf4;
  logic [3:0] a4, b4, sum4;
  // WIDTH = 1 instance
  logic       start1, cin1, busy1, done1, cout1, ovf1;
  logic [0:0] a1, b1, sum1;
  // WIDTH = 8 instance
  logic       start8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;

  serial_adder #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  serial_adder #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  // Independent reference: plain integer add plus sign-bit overflow rule.
  function automatic void model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                input logic cv, output logic [31:0] s,
                                output logic co, output logic ov);
    logic [32:0] full;
    logic [31:0] m;
    m    = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    full = {1'b0, av & m} + {1'b0, bv & m} + {32'd0, cv};
    s    = full[31:0] & m;
    co   = full[w];
    ov   = (av[w-1] == bv[w-1]) && (s[w-1] != av[w-1]);
  endfunction

  function automatic logic busy_of(input int w);
    case (w)
      4:       return busy4;
      1:       return busy1;
      default: return busy8;
    endcase
  endfunction

  function automatic int qsize(input int w);
    case (w)
      4:       return q4.size();
      1:       return q1.size();
      default: return q8.size();
    endcase
  endfunction

  task automatic push_exp(input int w, input logic [31:0] s, input logic co,
                          input logic ov, input longint acc);
    exp_t e;
    e.sum  = s;
    e.cout = co;
    e.ovf  = ov;
    e.cyc  = acc + w;
    case (w)
      4:       q4.push_back(e);
      1:       q1.push_back(e);
      default: q8.push_back(e);
    endcase
  endtask

  // Returns on a falling edge with the selected instance idle.
  task automatic wait_idle(input int w);
    @(negedge clk);
    for (int k = 0; k < 60 && busy_of(w); k++) @(negedge clk);
    if (busy_of(w)) fail_now($sformatf("w%0d idle timeout", w));
  endtask

  // Waits for every queued result to be delivered, then idles a few cycles
  // so a stray extra done pulse would be seen by the monitor.
  task automatic drain(input int w);
    for (int k = 0; k < 60 && qsize(w) != 0; k++) @(negedge clk);
    if (qsize(w) != 0) fail_now($sformatf("w%0d done timeout, %0d pending", w, qsize(w)));
    repeat (w + 3) @(negedge clk);
  endtask

  // One-cycle start pulse; returns on the falling edge after acceptance.
  task automatic issue(input int w, input logic [31:0] av, input logic [31:0] bv,
                       input logic cv, input logic push, input logic [31:0] es,
                       input logic eco, input logic eov);
    wait_idle(w);
    case (w)
      4: begin a4 = av[3:0]; b4 = bv[3:0]; cin4 = cv; start4 = 1'b1; end
      1: begin a1 = av[0:0]; b1 = bv[0:0]; cin1 = cv; start1 = 1'b1; end
      default: begin a8 = av[7:0]; b8 = bv[7:0]; cin8 = cv; start8 = 1'b1; end
    endcase
    if (push) push_exp(w, es, eco, eov, cyc + 1);
    @(negedge clk);
    start4 = 1'b0;
    start1 = 1'b0;
    start8 = 1'b0;
  endtask

  task automatic issue_ref(input int w, input logic [31:0] av, input logic [31:0] bv,
                           input logic cv);
    logic [31:0] s;
    logic        co, ov;
    model(w, av, bv, cv, s, co, ov);
    issue(w, av, bv, cv, 1'b1, s, co, ov);
  endtask

  task automatic compare(input string tag, input exp_t e, input logic [31:0] s,
                         input logic co, input logic ov);
    chk({tag, " sum"}, s, e.sum);
    chk({tag, " cout"}, {31'd0, co}, {31'd0, e.cout});
    chk({tag, " ovf"}, {31'd0, ov}, {31'd0, e.ovf});
    chk({tag, " done cycle"}, cyc[31:0], e.cyc[31:0]);
  endtask

  // Monitors: one per instance, sampling on the falling edge.
  always @(negedge clk) begin
    if (done4) begin
      if (q4.size() == 0) fail_now($sformatf("w4 unexpected done, sum=%0h", sum4));
      else compare("w4", q4.pop_front(), {28'd0, sum4}, cout4, ovf4);
    end
  end

  always @(negedge clk) begin
    if (done1) begin
      if (q1.size() == 0) fail_now($sformatf("w1 unexpected done, sum=%0h", sum1));
      else compare("w1", q1.pop_front(), {31'd0, sum1}, cout1, ovf1);
    end
  end

  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) fail_now($sformatf("w8 unexpected done, sum=%0h", sum8));
      else compare("w8", q8.pop_front(), {24'd0, sum8}, cout8, ovf8);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst busy", {31'd0, busy4}, 32'd0);
    chk("rst done", {31'd0, done4}, 32'd0);
    chk("rst sum", {28'd0, sum4}, 32'd0);
    chk("rst cout", {31'd0, cout4}, 32'd0);
    chk("rst ovf", {31'd0, ovf4}, 32'd0);
    rst_n = 1'b1;

    // 5+3: busy for exactly 4 cycles, done right after
    issue(4, 5, 3, 1'b0, 1'b1, 8, 1'b0, 1'b1);
    k = 0;
    while (busy4 && k < 10) begin
      k++;
      @(negedge clk);
    end
    chk("busy cycles", k, 4);
    chk("done after busy", {31'd0, done4}, 32'd1);

    // Directed WIDTH=4 vectors
    issue(4, 15, 1, 1'b0, 1'b1, 0, 1'b1, 1'b0);
    issue(4, 15, 15, 1'b1, 1'b1, 15, 1'b1, 1'b0);
    issue(4, 8, 8, 1'b0, 1'b1, 0, 1'b1, 1'b1);
    issue(4, 6, 5, 1'b1, 1'b1, 12, 1'b0, 1'b1);
    issue(4, 10, 3, 1'b0, 1'b1, 13, 1'b0, 1'b0);
    drain(4);

    // Start pulsed mid-RUN with new operands must be ignored
    issue(4, 7, 0, 1'b1, 1'b1, 8, 1'b0, 1'b1);
    @(negedge clk);
    a4 = 4'd1; b4 = 4'd1; cin4 = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    drain(4);
    chk("hold sum after ignored start", {28'd0, sum4}, 32'd8);

    // Start held high: 2+2 then 9+9 back to back, one done every 5 cycles
    wait_idle(4);
    a4 = 4'd2; b4 = 4'd2; cin4 = 1'b0; start4 = 1'b1;
    push_exp(4, 4, 1'b0, 1'b0, cyc + 1);
    repeat (5) @(negedge clk);
    a4 = 4'd9; b4 = 4'd9;
    push_exp(4, 2, 1'b1, 1'b1, cyc + 1);
    repeat (5) @(negedge clk);
    start4 = 1'b0;
    drain(4);

    // Asynchronous reset between RUN edges 2 and 3
    wait_idle(4);
    a4 = 4'd3; b4 = 4'd3; cin4 = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", {31'd0, busy4}, 32'd0);
    chk("abort done", {31'd0, done4}, 32'd0);
    chk("abort sum", {28'd0, sum4}, 32'd0);
    chk("abort cout", {31'd0, cout4}, 32'd0);
    chk("abort ovf", {31'd0, ovf4}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    issue(4, 1, 1, 1'b0, 1'b1, 2, 1'b0, 1'b0);
    drain(4);

    // WIDTH=1 exhaustive
    for (int i = 0; i < 8; i++) issue_ref(1, {31'd0, i[0]}, {31'd0, i[1]}, i[2]);
    drain(1);

    // WIDTH=8 directed corners, then random
    issue(8, 127, 1, 1'b0, 1'b1, 128, 1'b0, 1'b1);
    issue(8, 255, 255, 1'b1, 1'b1, 255, 1'b1, 1'b0);
    issue(8, 128, 128, 1'b0, 1'b1, 0, 1'b1, 1'b1);
    for (int i = 0; i < 1000; i++)
      issue_ref(8, {24'd0, 8'($urandom_range(0, 255))},
                {24'd0, 8'($urandom_range(0, 255))}, 1'($urandom_range(0, 1)));
    drain(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial ripple adder: the addition counterpart of the team's combinational full subtractor.
- Reuses one full-adder cell over WIDTH clock cycles, LSB first, with a registered carry.
- Produces sum, carry-out and a signed-overflow flag, with a start/busy/done handshake.
- Sits in the arithmetic library beside the subtractor cells, for area-constrained datapaths that tolerate WIDTH-cycle latency.

Parameters:
- WIDTH, 8, operand and sum width in bits (legal range 1..32).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; not overridden by users).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request: launch an addition when idle
- a  in  WIDTH  augend, sampled only on an accepted start
- b  in  WIDTH  addend, sampled only on an accepted start
- cin  in  1  carry-in, sampled only on an accepted start
- busy  out  1  high while an addition is in progress
- done  out  1  one-cycle pulse: sum/cout/ovf just updated
- sum  out  WIDTH  result bits, a+b+cin mod 2^WIDTH
- cout  out  1  unsigned carry-out
- ovf  out  1  two's-complement overflow, carry into MSB XOR carry out of MSB

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; busy, done, sum, cout, ovf, carry, counter and shift registers all 0.
  - Release is synchronous to the next clk edge.
- FSM states: IDLE, RUN.
- IDLE, start=1 sampled at edge E0:
  - Load a and b into shift registers; carry<=cin; count<=0; state<=RUN; busy=1 from E0.
- IDLE, start=0: hold; sum/cout/ovf keep the last completed result.
- RUN, each edge:
  - s = a_sh[0]^b_sh[0]^carry; carry <= majority(a_sh[0], b_sh[0], carry).
  - a_sh and b_sh shift right by one.
  - s shifts into the MSB of the result register, so after WIDTH shifts bit 0 is the LSB.
  - count increments.
- Bit i is processed at edge E(i+1).
- Last bit (count==WIDTH-1) at edge E(WIDTH):
  - sum <= result with the final s.
  - cout <= new carry.
  - ovf <= carry-in of MSB XOR new carry.
  - done <= 1; busy <= 0; state <= IDLE.
- Latency: done is high in the cycle after E(WIDTH), for exactly one cycle; it clears at E(WIDTH+1).
- Outputs sum/cout/ovf change only at a completion edge. Intermediate shift contents are never visible on sum.
- start while busy=1: ignored, with no effect on operands or count. The requester must re-assert it after done.
- Back-to-back: start held high through done is accepted at E(WIDTH+1), the first edge with state IDLE. Minimum issue interval is WIDTH+1 cycles.
- a/b/cin changes during RUN have no effect.
- WIDTH=1: single RUN edge; done follows one cycle after start; ovf = cin XOR cout.
- Reset mid-RUN: operation aborted; outputs zeroed; no done pulse; next start behaves as if from power-up.
- Counter never exceeds WIDTH-1; no wrap beyond it.

Test Plan:
- WIDTH=4, reset then start with a=5, b=3, cin=0 -> busy high 4 cycles; done pulses one cycle after the 4th RUN edge; sum=8, cout=0, ovf=1.
- WIDTH=4, a=15, b=1, cin=0 -> sum=0, cout=1, ovf=0; then a=15, b=15, cin=1 -> sum=15, cout=1, ovf=0.
- WIDTH=4, a=7, b=0, cin=1 -> sum=8, cout=0, ovf=1; start pulsed again mid-RUN with a=1, b=1 -> ignored, result still 8, exactly one done.
- start held high continuously, WIDTH=4, operands 2+2 then 9+9 -> done every 5 cycles; sums 4 then 2 (cout=1, ovf=1).
- rst_n driven low asynchronously between RUN edges 2 and 3 -> busy/done/sum/cout/ovf go 0 immediately, no done; next 1+1 gives sum=2.
- WIDTH=1 and WIDTH=8: exhaustive / 1000 random a, b, cin -> {cout,sum}==a+b+cin; ovf matches the signed reference; done latency always WIDTH cycles after start acceptance.
